btn_conditioner: RTL

- Input conditioning stage placed directly upstream of the LED sequencer.
- Takes raw, bouncing, active-low push-button pins and synchronises each into the clk domain.
- Debounces each channel and produces clean active-low levels, which the sequencer consumes in place of the raw pins.
- Also produces single-cycle press, release and long-press event pulses.
- One instance serves all board buttons; every channel is fully independent.

---
 rtl/btn_conditioner.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Push-button input conditioner. Synchronises raw active-low
//                button pins into the clk domain, then debounces each channel
//                into a clean active-low level. Also emits single-cycle
//                press, release and long-press pulses, plus a held flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int N_BTN             = 2,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    input  logic [N_BTN-1:0] btn_raw,      // 0 = pressed, asynchronous to clk
    output logic [N_BTN-1:0] btn_level,    // 0 = pressed, debounced
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_held
);

    // One counter width serves both the debounce and the hold counter. It is
    // wide enough to hold the larger threshold itself, so neither ever wraps.
    localparam int C_MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                  DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    localparam logic [C_CNT_W-1:0] C_DEB_LAST  = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_LONG_LAST = C_CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_LONG_MAX  = C_CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [C_CNT_W-1:0] C_ONE       = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s_sync;

        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [C_CNT_W-1:0]     r_deb_cnt;
        logic [C_CNT_W-1:0]     w_deb_cnt_nxt;
        logic [C_CNT_W-1:0]     r_hold_cnt;
        logic [C_CNT_W-1:0]     w_hold_cnt_nxt;
        logic                   r_level;
        logic                   w_level_nxt;
        logic                   r_press;
        logic                   w_press_nxt;
        logic                   r_release;
        logic                   w_release_nxt;
        logic                   r_long;
        logic                   w_long_nxt;
        logic                   r_held;
        logic                   w_held_nxt;

        // Synchroniser chain; resets to the released level so no false press appears.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync <= '1;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw[gi]};
            end
        end

        assign w_s_sync = r_sync[SYNC_STAGES-1];

        // FSM state, counters and registered outputs.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state    <= S_RELEASED;
                r_deb_cnt  <= '0;
                r_hold_cnt <= '0;
                r_level    <= 1'b1;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_long     <= 1'b0;
                r_held     <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_deb_cnt  <= w_deb_cnt_nxt;
                r_hold_cnt <= w_hold_cnt_nxt;
                r_level    <= w_level_nxt;
                r_press    <= w_press_nxt;
                r_release  <= w_release_nxt;
                r_long     <= w_long_nxt;
                r_held     <= w_held_nxt;
            end
        end

        // Next-state logic: debounce both edges, time the hold, form event pulses.
        always_comb begin
            w_state_nxt    = r_state;
            w_deb_cnt_nxt  = r_deb_cnt;
            w_hold_cnt_nxt = r_hold_cnt;
            w_level_nxt    = r_level;
            w_press_nxt    = 1'b0;
            w_release_nxt  = 1'b0;
            w_long_nxt     = 1'b0;
            w_held_nxt     = r_held;

            case (r_state)
                S_RELEASED: begin
                    if (!w_s_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // Single-cycle debounce accepts on the first differing sample.
                            w_state_nxt    = S_PRESSED;
                            w_level_nxt    = 1'b0;
                            w_press_nxt    = 1'b1;
                            w_hold_cnt_nxt = '0;
                            w_deb_cnt_nxt  = '0;
                        end else begin
                            w_state_nxt   = S_PRESS_WAIT;
                            w_deb_cnt_nxt = C_ONE;
                        end
                    end
                end

                S_PRESS_WAIT: begin
                    if (w_s_sync) begin
                        w_state_nxt   = S_RELEASED;
                        w_deb_cnt_nxt = '0;
                    end else if (r_deb_cnt == C_DEB_LAST) begin
                        w_state_nxt    = S_PRESSED;
                        w_level_nxt    = 1'b0;
                        w_press_nxt    = 1'b1;
                        w_hold_cnt_nxt = '0;
                        w_deb_cnt_nxt  = '0;
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + C_ONE;
                    end
                end

                S_PRESSED: begin
                    // Saturating hold count; it only returns to zero on a new press,
                    // so the threshold crossing happens at most once per press.
                    if (r_hold_cnt != C_LONG_MAX) begin
                        w_hold_cnt_nxt = r_hold_cnt + C_ONE;
                    end
                    if (w_s_sync && (DEBOUNCE_CYCLES == 1)) begin
                        // Release accepted on this edge wins over a coincident long press.
                        w_state_nxt    = S_RELEASED;
                        w_level_nxt    = 1'b1;
                        w_release_nxt  = 1'b1;
                        w_held_nxt     = 1'b0;
                        w_hold_cnt_nxt = '0;
                        w_deb_cnt_nxt  = '0;
                    end else begin
                        if (w_s_sync) begin
                            w_state_nxt   = S_RELEASE_WAIT;
                            w_deb_cnt_nxt = C_ONE;
                        end
                        if (r_hold_cnt == C_LONG_LAST) begin
                            w_long_nxt = 1'b1;
                            w_held_nxt = 1'b1;
                        end
                    end
                end

                S_RELEASE_WAIT: begin
                    if (!w_s_sync) begin
                        // Bounce back: the hold timer resumes rather than restarting.
                        w_state_nxt   = S_PRESSED;
                        w_deb_cnt_nxt = '0;
                    end else if (r_deb_cnt == C_DEB_LAST) begin
                        w_state_nxt    = S_RELEASED;
                        w_level_nxt    = 1'b1;
                        w_release_nxt  = 1'b1;
                        w_held_nxt     = 1'b0;
                        w_hold_cnt_nxt = '0;
                        w_deb_cnt_nxt  = '0;
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + C_ONE;
                    end
                end

                default: begin
                    w_state_nxt   = S_RELEASED;
                    w_deb_cnt_nxt = '0;
                end
            endcase
        end

        assign btn_level[gi]   = r_level;
        assign btn_press[gi]   = r_press;
        assign btn_release[gi] = r_release;
        assign btn_long[gi]    = r_long;
        assign btn_held[gi]    = r_held;
    end

endmodule
`default_nettype wire
